// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode map, flag bit positions
// and the controller state type.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBC  = 4'h3;
    localparam logic [3:0] OP_MUL  = 4'h4;
    localparam logic [3:0] OP_DIV  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_NOT  = 4'hB;
    localparam logic [3:0] OP_CMP  = 4'hC;
    localparam logic [3:0] OP_INC  = 4'hD;
    localparam logic [3:0] OP_DEC  = 4'hE;
    localparam logic [3:0] OP_PASS = 4'hF;

    localparam int FLAG_CARRY    = 0;
    localparam int FLAG_SIGN     = 1;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_ZERO     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_iter.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// A zero divisor naturally yields an all-ones quotient and remainder = dividend.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    // Bit WIDTH of the difference acts as the borrow of the trial subtraction.
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_divisor};
    assign w_fits  = ~w_diff[WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
        end else if (i_start) begin
            r_quot    <= i_dividend;
            r_rem     <= '0;
            r_divisor <= i_divisor;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
        end else if (r_busy) begin
            r_quot <= {r_quot[WIDTH-2:0], w_fits};
            r_rem  <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_cnt  <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign o_quotient  = r_quot;
    assign o_remainder = r_rem;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: single-cycle logic/arith ops,
// iterative shift-add multiply and an iterative divider sub-module.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int REGS_CODING = 3,
    parameter int FLAGS       = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [3:0]             i_opcode,
    input  logic [WIDTH-1:0]       i_op1,
    input  logic [WIDTH-1:0]       i_op2,
    input  logic                   i_cin,
    input  logic [REGS_CODING-1:0] i_dest_in,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [WIDTH-1:0]       o_result,
    output logic [WIDTH-1:0]       o_remainder,
    output logic [FLAGS-1:0]       o_flags,
    output logic [REGS_CODING-1:0] o_dest_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0]       r_result;
    logic [FLAGS-1:0]       r_flags;
    logic [REGS_CODING-1:0] r_dest;
    logic                   r_div_sel;
    logic                   r_div_zero;
    logic [WIDTH-1:0]       r_acc;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [CW-1:0]          r_cnt;

    logic                   w_accept;
    logic                   w_is_div;
    logic                   w_multi;
    logic                   w_last;
    logic [WIDTH-1:0]       w_addend;
    logic                   w_cin;
    logic                   w_sub;
    logic                   w_arith;
    logic [WIDTH:0]         w_sum;
    logic                   w_ovf;
    logic [WIDTH-1:0]       w_alu_result;
    logic [FLAGS-1:0]       w_alu_flags;
    logic [WIDTH-1:0]       w_mul_next;
    logic [FLAGS-1:0]       w_mul_flags;
    logic [FLAGS-1:0]       w_div_flags;
    logic                   w_div_busy;
    logic                   w_div_done;
    logic [WIDTH-1:0]       w_div_quot;
    logic [WIDTH-1:0]       w_div_rem;

    assign w_is_div = (i_opcode == OP_DIV);
    assign w_multi  = (i_opcode == OP_MUL) || w_is_div;
    assign w_accept = i_in_valid && o_in_ready;
    assign w_last   = r_div_sel ? (w_div_busy && w_div_done) : (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_in_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_next_state = w_multi ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (i_out_ready) begin
                    o_in_ready   = 1'b1;
                    w_next_state = i_in_valid ? (w_multi ? BUSY : DONE) : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Add/subtract family shares one WIDTH+1 bit adder; bit WIDTH is carry or borrow.
    always_comb begin
        w_addend = i_op2;
        w_cin    = 1'b0;
        w_sub    = 1'b0;
        w_arith  = 1'b0;
        case (i_opcode)
            OP_ADD: w_arith = 1'b1;
            OP_ADC: begin w_arith = 1'b1; w_cin = i_cin; end
            OP_SUB, OP_CMP: begin w_arith = 1'b1; w_sub = 1'b1; end
            OP_SBC: begin w_arith = 1'b1; w_sub = 1'b1; w_cin = i_cin; end
            OP_INC: begin w_arith = 1'b1; w_addend = WIDTH'(1); end
            OP_DEC: begin w_arith = 1'b1; w_sub = 1'b1; w_addend = WIDTH'(1); end
            default: ;
        endcase
    end

    assign w_sum = w_sub ? ({1'b0, i_op1} - {1'b0, w_addend} - {{WIDTH{1'b0}}, w_cin})
                         : ({1'b0, i_op1} + {1'b0, w_addend} + {{WIDTH{1'b0}}, w_cin});
    assign w_ovf = w_sub ? ((i_op1[WIDTH-1] != w_addend[WIDTH-1]) && (w_sum[WIDTH-1] != i_op1[WIDTH-1]))
                         : ((i_op1[WIDTH-1] == w_addend[WIDTH-1]) && (w_sum[WIDTH-1] != i_op1[WIDTH-1]));

    always_comb begin
        w_alu_result = w_sum[WIDTH-1:0];
        case (i_opcode)
            OP_AND:         w_alu_result = i_op1 & i_op2;
            OP_OR:          w_alu_result = i_op1 | i_op2;
            OP_XOR:         w_alu_result = i_op1 ^ i_op2;
            OP_SHL:         w_alu_result = i_op1 << i_op2;
            OP_SHR:         w_alu_result = i_op1 >> i_op2;
            OP_NOT:         w_alu_result = ~i_op1;
            OP_PASS:        w_alu_result = i_op1;
            OP_MUL, OP_DIV: w_alu_result = '0;
            default: ;
        endcase
        w_alu_flags                = '0;
        w_alu_flags[FLAG_CARRY]    = w_arith && w_sum[WIDTH];
        w_alu_flags[FLAG_OVERFLOW] = w_arith && w_ovf;
        w_alu_flags[FLAG_SIGN]     = w_alu_result[WIDTH-1];
        w_alu_flags[FLAG_ZERO]     = (w_alu_result == '0);
    end

    assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_mul_flags                = '0;
        w_mul_flags[FLAG_SIGN]     = w_mul_next[WIDTH-1];
        w_mul_flags[FLAG_ZERO]     = (w_mul_next == '0);
        w_div_flags                = '0;
        w_div_flags[FLAG_SIGN]     = w_div_quot[WIDTH-1];
        w_div_flags[FLAG_ZERO]     = (w_div_quot == '0);
        w_div_flags[FLAG_OVERFLOW] = r_div_zero;
    end

    // Single-cycle results land at accept; MUL results land on its final iteration.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result   <= '0;
            r_flags    <= '0;
            r_dest     <= '0;
            r_div_sel  <= 1'b0;
            r_div_zero <= 1'b0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_dest     <= i_dest_in;
            r_div_sel  <= w_is_div;
            r_div_zero <= (i_op2 == '0);
            r_acc      <= '0;
            r_mcand    <= i_op1;
            r_mplier   <= i_op2;
            r_cnt      <= '0;
            if (!w_multi) begin
                r_result <= w_alu_result;
                r_flags  <= w_alu_flags;
            end
        end else if (r_state == BUSY) begin
            r_acc    <= w_mul_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last && !r_div_sel) begin
                r_result <= w_mul_next;
                r_flags  <= w_mul_flags;
            end
        end
    end

    div_iter #(.WIDTH(WIDTH)) u_div (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (w_accept && w_is_div),
        .i_dividend  (i_op1),
        .i_divisor   (i_op2),
        .o_busy      (w_div_busy),
        .o_done      (w_div_done),
        .o_quotient  (w_div_quot),
        .o_remainder (w_div_rem)
    );

    // The divider holds its registers once idle, so DIV results are read straight from it.
    assign o_out_valid = (r_state == DONE);
    assign o_result    = r_div_sel ? w_div_quot : r_result;
    assign o_remainder = r_div_sel ? w_div_rem : '0;
    assign o_flags     = r_div_sel ? w_div_flags : r_flags;
    assign o_dest_out  = r_dest;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, hand-written handshake
// and reset sequences, then randomized ops against an arithmetic reference model.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int WIDTH  = 32;
    localparam int BUDGET = 100;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [2:0]  dest;
        logic [31:0] res;
        logic [31:0] rem;
        logic [3:0]  fl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [3:0]  opcode = 4'h0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        cin = 1'b0;
    logic [2:0]  destIn = '0;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [31:0] result;
    logic [31:0] remainder;
    logic [3:0]  flags;
    logic [2:0]  destOut;

    int   assertCount = 0;
    int   failCount = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(WIDTH), .REGS_CODING(3), .FLAGS(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .i_opcode    (opcode),
        .i_op1       (op1),
        .i_op2       (op2),
        .i_cin       (cin),
        .i_dest_in   (destIn),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_result    (result),
        .o_remainder (remainder),
        .o_flags     (flags),
        .o_dest_out  (destOut)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model built from plain integer arithmetic on the operation definitions.
    function automatic void refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic c, output logic [31:0] res, output logic [31:0] rem,
                                     output logic [3:0] fl);
        longint ua, ub, sa, sb, cv, u, s, maxU, minS, maxS;
        logic [63:0] prod;
        logic arith, divZero;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cv = c ? 64'sd1 : 64'sd0;
        maxU = 64'sh0000_0000_FFFF_FFFF;
        minS = -(64'sd1 <<< 31);
        maxS = (64'sd1 <<< 31) - 64'sd1;
        u = 0; s = 0; arith = 1'b0; divZero = 1'b0;
        res = '0; rem = '0; fl = '0;
        case (op)
            OP_ADD:  begin u = ua + ub;      s = sa + sb;      arith = 1'b1; end
            OP_ADC:  begin u = ua + ub + cv; s = sa + sb + cv; arith = 1'b1; end
            OP_SUB:  begin u = ua - ub;      s = sa - sb;      arith = 1'b1; end
            OP_SBC:  begin u = ua - ub - cv; s = sa - sb - cv; arith = 1'b1; end
            OP_CMP:  begin u = ua - ub;      s = sa - sb;      arith = 1'b1; end
            OP_INC:  begin u = ua + 1;       s = sa + 1;       arith = 1'b1; end
            OP_DEC:  begin u = ua - 1;       s = sa - 1;       arith = 1'b1; end
            OP_MUL:  begin prod = {32'd0, a} * {32'd0, b}; res = prod[31:0]; end
            OP_DIV: begin
                if (b == 0) begin res = 32'hFFFF_FFFF; rem = a; divZero = 1'b1; end
                else begin res = a / b; rem = a % b; end
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SHL:  res = (b >= 32) ? 32'd0 : (a << b);
            OP_SHR:  res = (b >= 32) ? 32'd0 : (a >> b);
            OP_NOT:  res = ~a;
            default: res = a;
        endcase
        if (arith) begin
            res = u[31:0];
            fl[FLAG_CARRY]    = (u < 0) || (u > maxU);
            fl[FLAG_OVERFLOW] = (s < minS) || (s > maxS);
        end
        if (divZero) fl[FLAG_OVERFLOW] = 1'b1;
        fl[FLAG_SIGN] = res[31];
        fl[FLAG_ZERO] = (res == 0);
    endfunction

    // Issues one op from a negedge with out_ready high, scrambles the inputs after
    // accept, measures latency and checks the held result.
    task automatic applyStimulus(input string name, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic c, input logic [2:0] dest,
                                 input logic [31:0] expRes, input logic [31:0] expRem,
                                 input logic [3:0] expFl);
        int expLat;
        int lat;
        expLat = (op == OP_MUL || op == OP_DIV) ? WIDTH + 1 : 1;
        lat = 0;
        opcode = op; op1 = a; op2 = b; cin = c; destIn = dest;
        inValid = 1'b1; outReady = 1'b1;
        #1 checkOutput({name, ".in_ready"}, 64'(inReady), 64'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        opcode = 4'($urandom); op1 = $urandom; op2 = $urandom;
        cin = 1'($urandom); destIn = 3'($urandom);
        for (int n = 1; n <= BUDGET; n++) begin
            @(negedge clk);
            if (outValid) begin
                lat = n;
                break;
            end
            checkOutput({name, ".busy_in_ready"}, 64'(inReady), 64'd0);
        end
        if (lat == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL %s.timeout: out_valid not seen within %0d cycles, expected %0d", name, BUDGET, expLat);
            return;
        end
        checkOutput({name, ".latency"}, 64'(lat), 64'(expLat));
        checkOutput({name, ".result"}, 64'(result), 64'(expRes));
        checkOutput({name, ".remainder"}, 64'(remainder), 64'(expRem));
        checkOutput({name, ".flags"}, 64'(flags), 64'(expFl));
        checkOutput({name, ".dest"}, 64'(destOut), 64'(dest));
    endtask

    task automatic addVec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [2:0] dest, input logic [31:0] res, input logic [31:0] rem,
                          input logic [3:0] fl);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.c = c; v.dest = dest;
        v.res = res; v.rem = rem; v.fl = fl;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]  rOp;
        logic [31:0] rA, rB, eRes, eRem;
        logic [3:0]  eFl;
        logic        rC;
        logic [2:0]  rDest;

        // flags vector order is {ZERO, OVERFLOW, SIGN, CARRY}
        addVec(OP_ADD,  32'hFFFF_FFFF, 32'h1,         1'b0, 3'd5, 32'h0,         32'h0, 4'b1001);
        addVec(OP_ADD,  32'h7FFF_FFFF, 32'h1,         1'b0, 3'd1, 32'h8000_0000, 32'h0, 4'b0110);
        addVec(OP_SUB,  32'h3,         32'h5,         1'b0, 3'd2, 32'hFFFF_FFFE, 32'h0, 4'b0011);
        addVec(OP_ADC,  32'h1,         32'h1,         1'b1, 3'd3, 32'h3,         32'h0, 4'b0000);
        addVec(OP_SBC,  32'h0,         32'h0,         1'b1, 3'd4, 32'hFFFF_FFFF, 32'h0, 4'b0011);
        addVec(OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 3'd6, 32'h00F0_00F0, 32'h0, 4'b0000);
        addVec(OP_OR,   32'h0000_00A0, 32'h0000_000B, 1'b0, 3'd7, 32'h0000_00AB, 32'h0, 4'b0000);
        addVec(OP_XOR,  32'hFF00_FF00, 32'hFFFF_0000, 1'b0, 3'd0, 32'h00FF_FF00, 32'h0, 4'b0000);
        addVec(OP_SHL,  32'h1,         32'd4,         1'b0, 3'd1, 32'h10,        32'h0, 4'b0000);
        addVec(OP_SHR,  32'h8000_0000, 32'd31,        1'b0, 3'd2, 32'h1,         32'h0, 4'b0000);
        addVec(OP_SHR,  32'h8000_0000, 32'd32,        1'b0, 3'd3, 32'h0,         32'h0, 4'b1000);
        addVec(OP_NOT,  32'h0,         32'h0,         1'b0, 3'd4, 32'hFFFF_FFFF, 32'h0, 4'b0010);
        addVec(OP_CMP,  32'h5,         32'h5,         1'b0, 3'd5, 32'h0,         32'h0, 4'b1000);
        addVec(OP_INC,  32'h7FFF_FFFF, 32'h0,         1'b0, 3'd6, 32'h8000_0000, 32'h0, 4'b0110);
        addVec(OP_DEC,  32'h0,         32'h0,         1'b0, 3'd7, 32'hFFFF_FFFF, 32'h0, 4'b0011);
        addVec(OP_PASS, 32'h1234_5678, 32'h0,         1'b0, 3'd0, 32'h1234_5678, 32'h0, 4'b0000);
        addVec(OP_DIV,  32'd100,       32'd7,         1'b0, 3'd1, 32'd14,        32'd2, 4'b0000);
        addVec(OP_DIV,  32'd5,         32'd0,         1'b0, 3'd2, 32'hFFFF_FFFF, 32'd5, 4'b0110);
        addVec(OP_MUL,  32'h0001_0000, 32'h0001_0000, 1'b0, 3'd3, 32'h0,         32'h0, 4'b1000);
        addVec(OP_MUL,  32'd3,         32'd5,         1'b0, 3'd4, 32'd15,        32'h0, 4'b0000);
        addVec(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'd5, 32'h1,         32'h0, 4'b0000);

        $display("[TB] reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset.out_valid", 64'(outValid), 64'd0);
        checkOutput("reset.in_ready", 64'(inReady), 64'd1);
        checkOutput("reset.result", 64'(result), 64'd0);
        checkOutput("reset.flags", 64'(flags), 64'd0);

        $display("[TB] directed vectors");
        foreach (vecs[i]) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c,
                          vecs[i].dest, vecs[i].res, vecs[i].rem, vecs[i].fl);
        end

        $display("[TB] backpressure hold and same-cycle retire/accept");
        @(posedge clk);
        @(negedge clk);
        opcode = OP_ADD; op1 = 32'd10; op2 = 32'd20; cin = 1'b0; destIn = 3'd2;
        inValid = 1'b1; outReady = 1'b0;
        @(posedge clk);
        #1;
        inValid = 1'b0; op1 = $urandom; op2 = $urandom;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold.out_valid", 64'(outValid), 64'd1);
            checkOutput("hold.in_ready", 64'(inReady), 64'd0);
            checkOutput("hold.result", 64'(result), 64'd30);
            checkOutput("hold.dest", 64'(destOut), 64'd2);
            @(negedge clk);
        end
        opcode = OP_ADD; op1 = 32'd1; op2 = 32'd2; destIn = 3'd3;
        inValid = 1'b1; outReady = 1'b1;
        #1 checkOutput("retire.in_ready", 64'(inReady), 64'd1);
        @(posedge clk);
        #1 inValid = 1'b0;
        @(negedge clk);
        checkOutput("retire.out_valid", 64'(outValid), 64'd1);
        checkOutput("retire.result", 64'(result), 64'd3);
        checkOutput("retire.dest", 64'(destOut), 64'd3);

        $display("[TB] reset during multiply");
        opcode = OP_MUL; op1 = 32'h1234; op2 = 32'h5678; destIn = 3'd6;
        inValid = 1'b1;
        @(posedge clk);
        #1 inValid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset.out_valid", 64'(outValid), 64'd0);
        checkOutput("midreset.in_ready", 64'(inReady), 64'd1);
        checkOutput("midreset.result", 64'(result), 64'd0);
        checkOutput("midreset.remainder", 64'(remainder), 64'd0);
        checkOutput("midreset.flags", 64'(flags), 64'd0);
        checkOutput("midreset.dest", 64'(destOut), 64'd0);
        applyStimulus("postreset_sub", OP_SUB, 32'd3, 32'd5, 1'b0, 3'd1, 32'hFFFF_FFFE, 32'h0, 4'b0011);

        $display("[TB] reset priority over handshakes");
        opcode = OP_ADD; op1 = 32'd1; op2 = 32'd1; destIn = 3'd7;
        inValid = 1'b1; outReady = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; inValid = 1'b0;
        @(negedge clk);
        checkOutput("rstprio.out_valid", 64'(outValid), 64'd0);
        checkOutput("rstprio.dest", 64'(destOut), 64'd0);

        $display("[TB] randomized ops");
        for (int k = 0; k < 40; k++) begin
            rOp = 4'($urandom_range(0, 15));
            rA = pickOperand();
            rB = (rOp == OP_SHL || rOp == OP_SHR) ? 32'($urandom_range(0, 40)) : pickOperand();
            rC = 1'($urandom);
            rDest = 3'($urandom);
            refModel(rOp, rA, rB, rC, eRes, eRem, eFl);
            applyStimulus($sformatf("rand%0d_op%0h", k, rOp), rOp, rA, rB, rC, rDest, eRes, eRem, eFl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
